// File: rtl/dlx_pipe_pkg.sv
// Shared DLX pipeline types: in-flight destination tracking entries and stage indices.
package dlx_pipe_pkg;

  localparam int REG_AW_MAX = 8;

  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

  localparam logic [REG_AW_MAX-1:0] REG_ZERO = '0;

  // rd is stored at the widest supported address width; narrower files zero-extend.
  typedef struct packed {
    logic                  valid;
    logic [REG_AW_MAX-1:0] rd;
    logic                  wr_en;
    logic                  is_load;
  } dlx_entry_t;

  localparam int ENTRY_W = $bits(dlx_entry_t);

  function automatic logic is_producer(input dlx_entry_t e);
    return e.valid & e.wr_en & (e.rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/dlx_fwd_port_sel.sv
// Per-read-port producer search: picks the youngest in-flight writer of rs_sel
// and either forwards its result or flags a hazard if the value is not yet produced.
module dlx_fwd_port_sel
  import dlx_pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int NUM_STAGES = 3,
  parameter int LOAD_READY = 1
) (
  input  logic [REG_AW-1:0]            rs_sel,
  input  logic                         used,
  input  logic [NUM_STAGES*ENTRY_W-1:0] entries,
  input  logic [NUM_STAGES*DATA_W-1:0] stage_result,
  input  logic [DATA_W-1:0]            rf_data,
  output logic [DATA_W-1:0]            fwd_data,
  output logic                         hazard
);

  dlx_entry_t [NUM_STAGES-1:0] ent;
  logic                        found;
  logic                        ready;
  logic [DATA_W-1:0]           win_data;

  assign ent = entries;

  // Scan oldest to youngest so the youngest match overwrites any older one.
  always_comb begin
    found    = 1'b0;
    ready    = 1'b0;
    win_data = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (is_producer(ent[k]) && (ent[k].rd == REG_AW_MAX'(rs_sel))) begin
        found    = 1'b1;
        ready    = ~ent[k].is_load | (k >= LOAD_READY);
        win_data = stage_result[k*DATA_W +: DATA_W];
      end
    end
  end

  assign fwd_data = (found & ready) ? win_data : rf_data;
  assign hazard   = used & found & ~ready;

endmodule

// File: rtl/dlx_hazard_fwd_unit.sv
// DLX hazard detection and operand forwarding: tracks in-flight writes after ID,
// forwards the youngest ready producer per read port, stalls decode otherwise.
module dlx_hazard_fwd_unit
  import dlx_pipe_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int REG_AW       = 5,
  parameter int NUM_STAGES   = STG_WB + 1,
  parameter int NUM_RD_PORTS = 2,
  parameter int LOAD_READY   = STG_MEM,
  parameter int CNT_W        = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           id_valid,
  input  logic [REG_AW-1:0]              id_rd,
  input  logic                           id_wr_en,
  input  logic                           id_is_load,
  input  logic [NUM_RD_PORTS*REG_AW-1:0] id_rs_sel,
  input  logic [NUM_RD_PORTS-1:0]        id_rs_used,
  input  logic [NUM_RD_PORTS*DATA_W-1:0] rf_data,
  input  logic [NUM_STAGES*DATA_W-1:0]   stage_result,
  input  logic                           flush,
  input  logic                           freeze,
  output logic [NUM_RD_PORTS*DATA_W-1:0] fwd_data,
  output logic                           stall,
  output logic [CNT_W-1:0]               stall_cycles
);

  dlx_entry_t [NUM_STAGES-1:0] entries;
  dlx_entry_t                  new_entry;
  logic [NUM_RD_PORTS-1:0]     hazard;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    dlx_fwd_port_sel #(
      .DATA_W    (DATA_W),
      .REG_AW    (REG_AW),
      .NUM_STAGES(NUM_STAGES),
      .LOAD_READY(LOAD_READY)
    ) u_sel (
      .rs_sel      (id_rs_sel[p*REG_AW +: REG_AW]),
      .used        (id_rs_used[p]),
      .entries     (entries),
      .stage_result(stage_result),
      .rf_data     (rf_data[p*DATA_W +: DATA_W]),
      .fwd_data    (fwd_data[p*DATA_W +: DATA_W]),
      .hazard      (hazard[p])
    );
  end

  assign stall = id_valid & ~flush & (|hazard);

  // A stalled or flushed ID slot enters EX as an all-zero bubble.
  always_comb begin
    new_entry = '0;
    if (id_valid & ~stall & ~flush) begin
      new_entry.valid   = 1'b1;
      new_entry.rd      = REG_AW_MAX'(id_rd);
      new_entry.wr_en   = id_wr_en;
      new_entry.is_load = id_is_load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries <= '0;
    end else if (!freeze) begin
      for (int k = NUM_STAGES - 1; k > 0; k--) begin
        entries[k] <= entries[k-1];
      end
      entries[STG_EX] <= new_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall && !freeze && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dlx_hazard_fwd_unit.sv
// Bench for dlx_hazard_fwd_unit: directed vector table, corner sequences,
// and randomized traffic checked against a queue-based pipeline model.
module tb_dlx_hazard_fwd_unit;

  localparam logic [31:0] RF0 = 32'hF0F0_0000;
  localparam logic [31:0] RF1 = 32'hF1F1_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid;
  logic [4:0]  id_rd;
  logic        id_wr_en;
  logic        id_is_load;
  logic [9:0]  id_rs_sel;
  logic [1:0]  id_rs_used;
  logic [63:0] rf_data;
  logic [95:0] stage_result;
  logic        flush;
  logic        freeze;
  logic [63:0] fwd_data;
  logic        stall;
  logic [15:0] stall_cycles;
  logic [63:0] fwd_data_s;
  logic        stall_s;
  logic [3:0]  stall_cycles_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dlx_hazard_fwd_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rd(id_rd),
    .id_wr_en(id_wr_en), .id_is_load(id_is_load), .id_rs_sel(id_rs_sel),
    .id_rs_used(id_rs_used), .rf_data(rf_data), .stage_result(stage_result),
    .flush(flush), .freeze(freeze), .fwd_data(fwd_data), .stall(stall),
    .stall_cycles(stall_cycles)
  );

  dlx_hazard_fwd_unit #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rd(id_rd),
    .id_wr_en(id_wr_en), .id_is_load(id_is_load), .id_rs_sel(id_rs_sel),
    .id_rs_used(id_rs_used), .rf_data(rf_data), .stage_result(stage_result),
    .flush(flush), .freeze(freeze), .fwd_data(fwd_data_s), .stall(stall_s),
    .stall_cycles(stall_cycles_s)
  );

  // Reference model: youngest-first queue of in-flight writes plus a stall tally.
  typedef struct {
    bit valid;
    int rd;
    bit wr;
    bit ld;
  } rec_t;

  rec_t pipe[$];
  int   model_cnt;

  function automatic void model_reset();
    rec_t empty;
    empty.valid = 1'b0; empty.rd = 0; empty.wr = 1'b0; empty.ld = 1'b0;
    pipe.delete();
    for (int k = 0; k < 3; k++) pipe.push_back(empty);
    model_cnt = 0;
  endfunction

  function automatic void model_port(input int rs, input bit used, input logic [31:0] rf,
                                     output logic [31:0] f, output bit hz);
    bit done;
    done = 1'b0;
    f = rf;
    hz = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!done && rs != 0 && pipe[k].valid && pipe[k].wr && pipe[k].rd == rs) begin
        done = 1'b1;
        if (pipe[k].ld && k < 1) hz = used;
        else f = stage_result[k*32 +: 32];
      end
    end
  endfunction

  function automatic void model_eval(output logic [31:0] f0, output logic [31:0] f1, output logic st);
    bit h0, h1;
    model_port(int'(id_rs_sel[4:0]), id_rs_used[0], rf_data[31:0], f0, h0);
    model_port(int'(id_rs_sel[9:5]), id_rs_used[1], rf_data[63:32], f1, h1);
    st = id_valid & ~flush & (h0 | h1);
  endfunction

  function automatic void model_update(input logic st);
    rec_t n;
    if (freeze) return;
    n.valid = id_valid & ~st & ~flush;
    n.rd    = int'(id_rd);
    n.wr    = id_wr_en;
    n.ld    = id_is_load;
    pipe.push_front(n);
    void'(pipe.pop_back());
    if (st) model_cnt++;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [4:0] rd, input logic wr, input logic ld,
                                input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used,
                                input logic fl, input logic fz);
    id_valid = v; id_rd = rd; id_wr_en = wr; id_is_load = ld;
    id_rs_sel = {rs1, rs0}; id_rs_used = used; flush = fl; freeze = fz;
  endtask

  // Check one cycle (explicit or model expectations), then clock it into the model.
  task automatic step(input bit use_model, input logic [31:0] ef0, input logic [31:0] ef1,
                      input logic est, input int ecnt);
    logic [31:0] mf0, mf1, x0, x1;
    logic mst, xst;
    int xc;
    #1;
    model_eval(mf0, mf1, mst);
    x0 = use_model ? mf0 : ef0;
    x1 = use_model ? mf1 : ef1;
    xst = use_model ? mst : est;
    xc = use_model ? model_cnt : ecnt;
    check_output("fwd0", fwd_data[31:0], x0);
    check_output("fwd1", fwd_data[63:32], x1);
    check_output("stall", {31'b0, stall}, {31'b0, xst});
    check_output("cnt", 32'(stall_cycles), 32'(xc));
    check_output("stall_sat", {31'b0, stall_s}, {31'b0, xst});
    check_output("cnt_sat", 32'(stall_cycles_s), 32'((xc > 15) ? 15 : xc));
    @(posedge clk);
    model_update(mst);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_output("rst_stall", {31'b0, stall}, 32'd0);
    check_output("rst_cnt", 32'(stall_cycles), 32'd0);
    check_output("rst_fwd0", fwd_data[31:0], rf_data[31:0]);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic v; logic [4:0] rd; logic wr; logic ld;
    logic [4:0] rs0; logic [4:0] rs1; logic [1:0] used; logic fl;
    logic [31:0] s0; logic [31:0] s1; logic [31:0] s2;
    logic [31:0] f0; logic [31:0] f1; logic st; int cnt;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b1, 5'd3, 1'b1, 1'b0, 5'd1, 5'd2, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, RF0, RF1, 1'b0, 0};
    tbl[1] = '{1'b1, 5'd4, 1'b1, 1'b1, 5'd3, 5'd0, 2'b01, 1'b0, 32'h11, 32'h0, 32'h0, 32'h11, RF1, 1'b0, 0};
    tbl[2] = '{1'b1, 5'd6, 1'b1, 1'b0, 5'd4, 5'd3, 2'b01, 1'b0, 32'h0, 32'h22, 32'h0, RF0, 32'h22, 1'b1, 0};
    tbl[3] = '{1'b1, 5'd6, 1'b1, 1'b0, 5'd4, 5'd3, 2'b01, 1'b0, 32'h0, 32'hCAFE, 32'h33, 32'hCAFE, 32'h33, 1'b0, 1};
    tbl[4] = '{1'b1, 5'd5, 1'b1, 1'b1, 5'd6, 5'd4, 2'b11, 1'b0, 32'h66, 32'h0, 32'h44, 32'h66, 32'h44, 1'b0, 1};
    tbl[5] = '{1'b1, 5'd5, 1'b1, 1'b0, 5'd5, 5'd5, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, RF0, RF1, 1'b0, 1};
    tbl[6] = '{1'b1, 5'd0, 1'b1, 1'b0, 5'd5, 5'd6, 2'b11, 1'b0, 32'hA, 32'hB, 32'hC, 32'hA, 32'hC, 1'b0, 1};
    tbl[7] = '{1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 5'd5, 2'b11, 1'b0, 32'hD00D, 32'hE, 32'h0, RF0, 32'hE, 1'b0, 1};
    tbl[8] = '{1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 5'd0, 2'b01, 1'b1, 32'h0, 32'h0, 32'h0, RF0, RF1, 1'b0, 1};
    tbl[9] = '{1'b0, 5'd0, 1'b0, 1'b0, 5'd8, 5'd7, 2'b01, 1'b0, 32'h88, 32'h77, 32'h0, RF0, 32'h77, 1'b0, 1};

    apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    rf_data = {RF1, RF0};
    stage_result = '0;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      apply_stimulus(tbl[i].v, tbl[i].rd, tbl[i].wr, tbl[i].ld, tbl[i].rs0, tbl[i].rs1,
                     tbl[i].used, tbl[i].fl, 1'b0);
      stage_result = {tbl[i].s2, tbl[i].s1, tbl[i].s0};
      step(1'b0, tbl[i].f0, tbl[i].f1, tbl[i].st, tbl[i].cnt);
    end

    // Freeze holding a load-use hazard, then flush together with freeze.
    do_reset();
    stage_result = {32'h3, 32'h9999, 32'h1};
    apply_stimulus(1'b1, 5'd9, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    step(1'b0, RF0, RF1, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 5'd2, 1'b1, 1'b0, 5'd9, 5'd0, 2'b01, 1'b0, 1'b1);
      step(1'b0, RF0, RF1, 1'b1, 0);
    end
    apply_stimulus(1'b1, 5'd2, 1'b1, 1'b0, 5'd9, 5'd0, 2'b01, 1'b0, 1'b0);
    step(1'b0, RF0, RF1, 1'b1, 0);
    step(1'b0, 32'h9999, RF1, 1'b0, 1);
    apply_stimulus(1'b1, 5'd10, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    step(1'b0, RF0, RF1, 1'b0, 1);
    apply_stimulus(1'b1, 5'd3, 1'b1, 1'b0, 5'd10, 5'd0, 2'b01, 1'b1, 1'b1);
    step(1'b0, RF0, RF1, 1'b0, 1);
    apply_stimulus(1'b1, 5'd3, 1'b1, 1'b0, 5'd10, 5'd0, 2'b01, 1'b0, 1'b0);
    step(1'b0, RF0, RF1, 1'b1, 1);

    // Asynchronous reset in the middle of a stall.
    apply_stimulus(1'b1, 5'd9, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    step(1'b1, 32'h0, 32'h0, 1'b0, 0);
    apply_stimulus(1'b1, 5'd2, 1'b1, 1'b0, 5'd9, 5'd0, 2'b01, 1'b0, 1'b0);
    #1;
    check_output("pre_rst_stall", {31'b0, stall}, 32'd1);
    check_output("pre_rst_cnt", 32'(stall_cycles), 32'd2);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_output("mid_rst_stall", {31'b0, stall}, 32'd0);
    check_output("mid_rst_fwd0", fwd_data[31:0], RF0);
    check_output("mid_rst_cnt", 32'(stall_cycles), 32'd0);
    check_output("mid_rst_cnt_sat", 32'(stall_cycles_s), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // A self-dependent load stalls every other cycle: 20 stalls in 40 cycles.
    apply_stimulus(1'b1, 5'd9, 1'b1, 1'b1, 5'd9, 5'd0, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 32'h0, 32'h0, 1'b0, 0);
    check_output("sat_cnt16", 32'(stall_cycles), 32'd20);
    check_output("sat_cnt4", 32'(stall_cycles_s), 32'd15);

    for (int i = 0; i < 400; i++) begin
      apply_stimulus(1'($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)),
                     1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     2'($urandom_range(0, 3)), 1'($urandom_range(0, 9) == 0),
                     1'($urandom_range(0, 7) == 0));
      rf_data = {$urandom(), $urandom()};
      stage_result = {$urandom(), $urandom(), $urandom()};
      step(1'b1, 32'h0, 32'h0, 1'b0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
